// File: rtl/booth_action_encoder.sv
// Radix-4 Booth recoder: scans one multiplier operand two bits per group.
// Emits one action code per group over a valid/ready stream.
module booth_action_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       action,
  output logic [IDX_W-1:0] group_idx,
  output logic             last,
  output logic             busy
);

  localparam int HALF = WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_S = IDX_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_U = IDX_W'(HALF);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t           state;
  logic [WIDTH:0]   sr;
  logic [WIDTH:0]   sr_nxt;
  logic             sgn;
  logic             fill;
  logic [IDX_W-1:0] idx_last;
  logic [IDX_W-1:0] idx_nxt;

  function automatic logic [2:0] recode(
    input logic [2:0] t
  );
    logic [2:0] a;
    unique case (t)
      3'b000:  a = 3'd0;
      3'b001:  a = 3'd1;
      3'b010:  a = 3'd1;
      3'b011:  a = 3'd2;
      3'b100:  a = 3'd4;
      3'b101:  a = 3'd3;
      3'b110:  a = 3'd3;
      default: a = 3'd0;
    endcase
    return a;
  endfunction

  // Next shift-register contents: sign- or zero-extend by one group.
  always_comb begin
    fill    = sgn & sr[WIDTH];
    sr_nxt  = {fill, fill, sr[WIDTH:2]};
    idx_nxt = group_idx + 1'b1;
  end

  // Current action decoded from the low triplet; zero outside EMIT.
  always_comb begin
    action = 3'd0;
    if (state == EMIT) begin
      action = recode(sr[2:0]);
    end
  end

  // Control FSM with registered handshake and group outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      sgn       <= 1'b0;
      idx_last  <= '0;
      group_idx <= '0;
      last      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr        <= {multiplier, 1'b0};
            sgn       <= is_signed;
            idx_last  <= is_signed ? LAST_S : LAST_U;
            group_idx <= '0;
            last      <= 1'b0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last) begin
              group_idx <= '0;
              last      <= 1'b0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              sr        <= sr_nxt;
              group_idx <= idx_nxt;
              last      <= (idx_nxt == idx_last);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
